fma_issue_stage: RTL and testbench

Upstream operand-issue stage for the fused multiply-add datapath. Accepts FMA-class requests over a valid/ready handshake and decodes the four variants (FMADD/FMSUB/FNMSUB/FNMADD) into sign-adjusted operands. Resolves the dynamic rounding mode against frm. Buffers requests in a small FIFO and presents the head entry as in1/in2/in3/rm directly to the FMA unit, with a valid/ready handshake to the consumer.

---
 rtl/fma_issue_stage.sv | 142 ++++++++++++++
 tb/tb_fma_issue_stage.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fma_issue_stage.sv
// rtl/fma_issue_stage.sv - FMA operand-issue stage with sign adjustment, rm resolution and FIFO buffering
//
// Accepts FMADD/FMSUB/FNMSUB/FNMADD requests, applies the variant's sign flips to
// rs1/rs3, resolves the dynamic rounding mode against frm, and queues the result in
// a DEPTH-entry FIFO whose head drives the FMA unit.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   flush             synchronous clear of all buffered entries (beats a same-cycle accept)
//   in_valid/in_ready request handshake; in_ready = not full
//   in_op             00 FMADD, 01 FMSUB, 10 FNMSUB, 11 FNMADD
//   in_a/in_b/in_c    rs1/rs2/rs3, IEEE-754 single
//   in_rm, frm        instruction rounding mode, dynamic rounding mode
//   in_tag            opaque destination tag
//   out_valid/out_ready head-entry handshake
//   out_a/out_b/out_c sign-adjusted operands of the head entry
//   out_rm, out_illegal resolved rounding mode, illegal-rm flag
//   out_tag           tag of the head entry
//   count             number of occupied entries
module fma_issue_stage #(
  parameter int DEPTH = 2,
  parameter int TAG_W = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_op,
  input  logic [31:0]            in_a,
  input  logic [31:0]            in_b,
  input  logic [31:0]            in_c,
  input  logic [2:0]             in_rm,
  input  logic [TAG_W-1:0]       in_tag,
  input  logic [2:0]             frm,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_a,
  output logic [31:0]            out_b,
  output logic [31:0]            out_c,
  output logic [2:0]             out_rm,
  output logic [TAG_W-1:0]       out_tag,
  output logic                   out_illegal,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [31:0]      mem_a   [DEPTH];
  logic [31:0]      mem_b   [DEPTH];
  logic [31:0]      mem_c   [DEPTH];
  logic [2:0]       mem_rm  [DEPTH];
  logic [TAG_W-1:0] mem_tag [DEPTH];
  logic             mem_ill [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic push;
  logic pop;

  logic [31:0] adj_a;
  logic [31:0] adj_c;
  logic [2:0]  res_rm;
  logic        res_ill;

  assign in_ready  = (count != FULL_CNT);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  // op[1] negates the product (flip rs1), op[0] negates the addend (flip rs3)
  // except FNMADD, which negates both; in every case the table works out to
  // a flipped for 10/11 and c flipped for 01/11.
  always_comb begin
    adj_a     = in_a;
    adj_c     = in_c;
    adj_a[31] = in_a[31] ^ in_op[1];
    adj_c[31] = in_c[31] ^ in_op[0];
  end

  // 101/110 are reserved; 111 selects frm, which itself may hold a reserved value.
  always_comb begin
    res_rm  = in_rm;
    res_ill = 1'b0;
    if (in_rm == 3'b111) begin
      if (frm >= 3'b101) begin
        res_rm  = 3'b000;
        res_ill = 1'b1;
      end else begin
        res_rm  = frm;
      end
    end else if (in_rm >= 3'b101) begin
      res_rm  = 3'b000;
      res_ill = 1'b1;
    end
  end

  // Payload storage needs no reset: outputs are masked by out_valid below.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr]   <= adj_a;
      mem_b[wr_ptr]   <= in_b;
      mem_c[wr_ptr]   <= adj_c;
      mem_rm[wr_ptr]  <= res_rm;
      mem_tag[wr_ptr] <= in_tag;
      mem_ill[wr_ptr] <= res_ill;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Gating by out_valid keeps the outputs at zero whenever the FIFO is empty,
  // including immediately on asynchronous reset.
  assign out_a       = out_valid ? mem_a[rd_ptr]   : '0;
  assign out_b       = out_valid ? mem_b[rd_ptr]   : '0;
  assign out_c       = out_valid ? mem_c[rd_ptr]   : '0;
  assign out_rm      = out_valid ? mem_rm[rd_ptr]  : '0;
  assign out_tag     = out_valid ? mem_tag[rd_ptr] : '0;
  assign out_illegal = out_valid ? mem_ill[rd_ptr] : 1'b0;

endmodule

// File: tb/tb_fma_issue_stage.sv
// tb/tb_fma_issue_stage.sv - scoreboard bench for fma_issue_stage
module tb_fma_issue_stage;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, c;
    logic [2:0]  rm, frm;
    logic [4:0]  tag;
    logic [31:0] ea, ec;
    logic [2:0]  erm;
    logic        eill;
  } vec_t;

  typedef struct {
    logic [31:0] a, b, c;
    logic [2:0]  rm;
    logic [4:0]  tag;
    logic        ill;
  } exp_t;

  logic        clk, rst_n, flush;
  logic        in_valid, in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_a, in_b, in_c;
  logic [2:0]  in_rm, frm;
  logic [4:0]  in_tag;
  logic        out_valid, out_ready;
  logic [31:0] out_a, out_b, out_c;
  logic [2:0]  out_rm;
  logic [4:0]  out_tag;
  logic        out_illegal;
  logic [1:0]  count;

  fma_issue_stage #(.DEPTH(2), .TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_rm(in_rm), .in_tag(in_tag), .frm(frm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_c(out_c), .out_rm(out_rm),
    .out_tag(out_tag), .out_illegal(out_illegal), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  int   pops = 0;
  exp_t cur_exp;
  exp_t sb[$];
  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] op, input logic [31:0] a, input logic [31:0] c,
                              input logic [2:0] rm, input logic [2:0] f, input logic [4:0] tag,
                              input logic [31:0] ea, input logic [31:0] ec,
                              input logic [2:0] erm, input logic eill);
    vec_t v;
    v.op = op; v.a = a; v.b = 32'h40000000; v.c = c; v.rm = rm; v.frm = f; v.tag = tag;
    v.ea = ea; v.ec = ec; v.erm = erm; v.eill = eill;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    in_valid = 1'b1; in_op = v.op; in_a = v.a; in_b = v.b; in_c = v.c;
    in_rm = v.rm; frm = v.frm; in_tag = v.tag;
    cur_exp.a = v.ea; cur_exp.b = v.b; cur_exp.c = v.ec;
    cur_exp.rm = v.erm; cur_exp.tag = v.tag; cur_exp.ill = v.eill;
  endtask

  function automatic vec_t plain(input logic [4:0] tag);
    return mk(2'b00, 32'h3F800000, 32'h40400000, 3'b000, 3'b000, tag,
              32'h3F800000, 32'h40400000, 3'b000, 1'b0);
  endfunction

  // Send one vector and wait (bounded) for it to be accepted.
  task automatic send(input vec_t v);
    int n;
    drive(v);
    n = 0;
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 20) begin
        chk("send_timeout", 32'(in_ready), 32'd1);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Monitor and accept observer; both sample at the falling edge.
  always @(negedge clk) begin
    if (!rst_n || flush) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        pops++;
        if (sb.size() == 0) begin
          chk("sb_unexpected_pop", 32'(out_tag), 32'h0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checks++;
          if (out_a !== e.a || out_b !== e.b || out_c !== e.c || out_rm !== e.rm ||
              out_tag !== e.tag || out_illegal !== e.ill) begin
            failures++;
            $display("FAIL sb_entry got a=%h b=%h c=%h rm=%0d tag=%0d ill=%0d want a=%h b=%h c=%h rm=%0d tag=%0d ill=%0d",
                     out_a, out_b, out_c, out_rm, out_tag, out_illegal,
                     e.a, e.b, e.c, e.rm, e.tag, e.ill);
          end
        end
      end
      if (in_valid && in_ready) sb.push_back(cur_exp);
    end
  end

  initial begin
    vecs[0] = mk(2'b00, 32'h3F800000, 32'h40400000, 3'b000, 3'b000, 5'd3,  32'h3F800000, 32'h40400000, 3'b000, 1'b0);
    vecs[1] = mk(2'b01, 32'h3F800000, 32'h40400000, 3'b000, 3'b000, 5'd4,  32'h3F800000, 32'hC0400000, 3'b000, 1'b0);
    vecs[2] = mk(2'b10, 32'h3F800000, 32'h40400000, 3'b000, 3'b000, 5'd5,  32'hBF800000, 32'h40400000, 3'b000, 1'b0);
    vecs[3] = mk(2'b11, 32'h3F800000, 32'h40400000, 3'b000, 3'b000, 5'd6,  32'hBF800000, 32'hC0400000, 3'b000, 1'b0);
    vecs[4] = mk(2'b00, 32'h3F800000, 32'h40400000, 3'b111, 3'b011, 5'd7,  32'h3F800000, 32'h40400000, 3'b011, 1'b0);
    vecs[5] = mk(2'b00, 32'h3F800000, 32'h40400000, 3'b101, 3'b000, 5'd8,  32'h3F800000, 32'h40400000, 3'b000, 1'b1);
    vecs[6] = mk(2'b00, 32'h3F800000, 32'h40400000, 3'b111, 3'b110, 5'd9,  32'h3F800000, 32'h40400000, 3'b000, 1'b1);
    vecs[7] = mk(2'b00, 32'h3F800000, 32'h40400000, 3'b110, 3'b010, 5'd10, 32'h3F800000, 32'h40400000, 3'b000, 1'b1);
    vecs[8] = mk(2'b00, 32'h3F800000, 32'h40400000, 3'b100, 3'b010, 5'd11, 32'h3F800000, 32'h40400000, 3'b100, 1'b0);
    vecs[9] = mk(2'b11, 32'h80000000, 32'h7FC00000, 3'b111, 3'b000, 5'd12, 32'h00000000, 32'hFFC00000, 3'b000, 1'b0);

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_a = '0; in_b = '0; in_c = '0; in_rm = '0; frm = '0; in_tag = '0;
    cur_exp = '{default: '0};
    #2;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_a", out_a, 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed decode / rounding vectors, one at a time into an empty FIFO.
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send(vecs[i]);
      chk("latency_out_valid", 32'(out_valid), 32'd1);
      @(posedge clk); #1;
    end
    chk("drained_count", 32'(count), 32'd0);

    // Backpressure: three offers into a 2-deep FIFO.
    out_ready = 1'b0;
    drive(plain(5'd1));
    @(posedge clk); #1;
    drive(plain(5'd2));
    @(posedge clk); #1;
    drive(plain(5'd3));
    chk("full_count", 32'(count), 32'd2);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_head_tag", 32'(out_tag), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    chk("hold_count", 32'(count), 32'd2);
    chk("hold_head_tag", 32'(out_tag), 32'd1);
    chk("hold_head_a", out_a, 32'h3F800000);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("bp_drained", 32'(count), 32'd0);

    // Sustained streaming at count=1 across pointer wrap.
    out_ready = 1'b0;
    drive(plain(5'd0));
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      drive(plain(5'(t)));
      @(posedge clk); #1;
      chk("stream_count", 32'(count), 32'd1);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("stream_drained", 32'(count), 32'd0);

    // Flush beats a same-cycle accept (count=1, accept possible).
    out_ready = 1'b0;
    drive(plain(5'd20));
    @(posedge clk); #1;
    chk("pre_flush1_count", 32'(count), 32'd1);
    drive(plain(5'd21));
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush1_count", 32'(count), 32'd0);
    chk("flush1_out_valid", 32'(out_valid), 32'd0);

    // Flush with a full FIFO and an offered request.
    drive(plain(5'd22));
    @(posedge clk); #1;
    drive(plain(5'd23));
    @(posedge clk); #1;
    chk("pre_flush2_count", 32'(count), 32'd2);
    drive(plain(5'd24));
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush2_count", 32'(count), 32'd0);
    chk("flush2_out_valid", 32'(out_valid), 32'd0);

    // Asynchronous reset mid-stream.
    drive(plain(5'd25));
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("pre_rst_count", 32'(count), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_a", out_a, 32'd0);
    chk("arst_out_tag", 32'(out_tag), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("pop_total", 32'(pops), 32'd23);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
